// File: rtl/flt_to_int_seq_pkg.sv
// Shared mini-float field layout, FSM encodings and saturation constant.
// The int-to-float encoder uses the same field constants.
package flt_to_int_seq_pkg;

    localparam int MAN_W = 8;
    localparam int EXP_W = 4;
    localparam int INT_W = 8;
    localparam int FLT_W = 1 + EXP_W + MAN_W;

    localparam int SIGN_B = FLT_W - 1;
    localparam int EXP_HI = FLT_W - 2;
    localparam int EXP_LO = MAN_W;
    localparam int MAN_HI = MAN_W - 1;
    localparam int MAN_LO = 0;

    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(MAN_W);
    localparam logic [INT_W-2:0] SAT_MAG = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/flt_to_int_seq.sv
// Sequential mini-float to sign-magnitude integer converter, one shift per clock.
// Define ROUND_NEAREST_EN to round half up on the magnitude instead of truncating.
module flt_to_int_seq
    import flt_to_int_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLT_W-1:0] in_flt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             out_ovf
);

    state_t             state;
    logic               sign_q;
    logic [MAN_W-1:0]   wreg;
    logic [EXP_W-1:0]   cnt;

    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_man;
    logic [EXP_W-1:0]   cnt_init;
    logic [MAN_W-1:0]   src;
    logic [MAN_W-1:0]   sh;
    logic               last;
    logic [INT_W-2:0]   mag;
    logic               ovf;

    assign in_exp   = in_flt[EXP_HI:EXP_LO];
    assign in_man   = in_flt[MAN_HI:MAN_LO];
    assign cnt_init = EXP_SAT - in_exp;

    // The first shift happens on the accept edge, so exp=7 lands in DONE
    // with the same one-cycle latency as the zero and saturate cases.
    always_comb begin
        src  = (state == ST_IDLE) ? in_man : wreg;
        sh   = src >> 1;
        last = (state == ST_IDLE) ? (cnt_init == EXP_W'(1))
                                  : (cnt == EXP_W'(1));
        ovf  = |sh[MAN_W-1:INT_W-1];
        mag  = sh[INT_W-2:0];
`ifdef ROUND_NEAREST_EN
        begin
            logic [INT_W-1:0] sum;
            sum = {1'b0, sh[INT_W-2:0]} + INT_W'(src[0]);
            mag = sum[INT_W-2:0];
            ovf = ovf | sum[INT_W-1];
        end
`endif
        if (ovf)
            mag = SAT_MAG;
    end

`ifndef ROUND_NEAREST_EN
    logic unused_guard;
    assign unused_guard = src[0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_int   <= '0;
            out_ovf   <= 1'b0;
            cnt       <= '0;
            wreg      <= '0;
            sign_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_flt[SIGN_B];
                        unique case (1'b1)
                            (in_exp == '0): begin
                                out_int   <= {in_flt[SIGN_B], {(INT_W-1){1'b0}}};
                                out_ovf   <= 1'b0;
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= ST_DONE;
                            end
                            (in_exp >= EXP_SAT): begin
                                out_int   <= {in_flt[SIGN_B], SAT_MAG};
                                out_ovf   <= 1'b1;
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= ST_DONE;
                            end
                            last: begin
                                out_int   <= {in_flt[SIGN_B], mag};
                                out_ovf   <= ovf;
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                                state     <= ST_DONE;
                            end
                            default: begin
                                wreg     <= sh;
                                cnt      <= cnt_init - EXP_W'(1);
                                in_ready <= 1'b0;
                                state    <= ST_SHIFT;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    wreg <= sh;
                    cnt  <= cnt - EXP_W'(1);
                    if (last) begin
                        out_int   <= {sign_q, mag};
                        out_ovf   <= ovf;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flt_to_int_seq.sv
// Directed bench for flt_to_int_seq; expected values are hand-computed.
// Build with ROUND_NEAREST_EN to check the rounding variant.
module tb_flt_to_int_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_flt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_int;
    logic        out_ovf;

    int total = 0;
    int passed = 0;

    flt_to_int_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flt    (in_flt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] flt;
        logic [7:0]  res;
        logic        ovf;
        int          lat;
    } vec_t;

    // Presents f, waits for out_valid (out_ready assumed 1), completes the
    // handshake. lat counts edges from the accept edge; -1 on timeout.
    task automatic do_xfer(input logic [12:0] f, output logic [7:0] o,
                           output logic ov, output int lat);
        in_flt   = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        o  = out_int;
        ov = out_ovf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_flt    = '0;
        out_ready = 1'b1;
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_int !== 8'h00 || out_ovf !== 1'b0)
            $display("FAIL reset: rdy=%b vld=%b int=%h ovf=%b want 1 0 00 0",
                     in_ready, out_valid, out_int, out_ovf);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        vec_t v[$];
        logic [7:0] o;
        logic       ov;
        int         lat;
        v.push_back('{13'h07FE, 8'h7F, 1'b0, 1});
        v.push_back('{13'h1180, 8'h81, 1'b0, 7});
`ifdef ROUND_NEAREST_EN
        v.push_back('{13'h01C0, 8'h02, 1'b0, 7});
        v.push_back('{13'h07FF, 8'h7F, 1'b1, 1});
        v.push_back('{13'h05B4, 8'h17, 1'b0, 3});
        v.push_back('{13'h1355, 8'h83, 1'b0, 5});
`else
        v.push_back('{13'h01C0, 8'h01, 1'b0, 7});
        v.push_back('{13'h07FF, 8'h7F, 1'b0, 1});
        v.push_back('{13'h05B4, 8'h16, 1'b0, 3});
        v.push_back('{13'h1355, 8'h82, 1'b0, 5});
`endif
        v.push_back('{13'h0000, 8'h00, 1'b0, 1});
        v.push_back('{13'h1000, 8'h80, 1'b0, 1});
        v.push_back('{13'h00FF, 8'h00, 1'b0, 1});
        v.push_back('{13'h0980, 8'h7F, 1'b1, 1});
        v.push_back('{13'h0801, 8'h7F, 1'b1, 1});
        v.push_back('{13'h1FFF, 8'hFF, 1'b1, 1});
        v.push_back('{13'h0440, 8'h04, 1'b0, 4});
        v.push_back('{13'h0620, 8'h08, 1'b0, 2});
        foreach (v[i]) begin
            do_xfer(v[i].flt, o, ov, lat);
            total++;
            if (o !== v[i].res)
                $display("FAIL int[%h]: got %h want %h", v[i].flt, o, v[i].res);
            else passed++;
            total++;
            if (ov !== v[i].ovf)
                $display("FAIL ovf[%h]: got %b want %b", v[i].flt, ov, v[i].ovf);
            else passed++;
            total++;
            if (lat != v[i].lat)
                $display("FAIL lat[%h]: got %0d want %0d", v[i].flt, lat, v[i].lat);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] o;
        logic       ov;
        int         lat;
        do_xfer(13'h0640, o, ov, lat);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b_idle: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        else passed++;
        do_xfer(13'h1740, o, ov, lat);
        total++;
        if (o !== 8'hA0 || lat != 1)
            $display("FAIL b2b_second: int=%h lat=%0d want a0 1", o, lat);
        else passed++;
    endtask

    task automatic test_backpressure();
        int wait_n;
        out_ready = 1'b0;
        in_flt    = 13'h0410;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        total++;
        if (out_valid !== 1'b1 || out_int !== 8'h01)
            $display("FAIL bp_result: vld=%b int=%h want 1 01", out_valid, out_int);
        else passed++;
        in_flt   = 13'h07FE;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_int !== 8'h01 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: vld=%b int=%h rdy=%b want 1 01 0",
                         i, out_valid, out_int, in_ready);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_int !== 8'h7F || in_ready !== 1'b0)
            $display("FAIL bp_next: vld=%b int=%h rdy=%b want 1 7f 0",
                     out_valid, out_int, in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        logic [7:0] o;
        logic       ov;
        int         lat;
        out_ready = 1'b1;
        in_flt    = 13'h1180;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL rst_busy: rdy=%b want 0", in_ready);
        else passed++;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_int !== 8'h00)
            $display("FAIL rst_async: rdy=%b vld=%b int=%h want 1 0 00",
                     in_ready, out_valid, out_int);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL rst_stale: out_valid cycles=%0d want 0", seen);
        else passed++;
        do_xfer(13'h07FE, o, ov, lat);
        total++;
        if (o !== 8'h7F || ov !== 1'b0 || lat != 1)
            $display("FAIL rst_recover: int=%h ovf=%b lat=%0d want 7f 0 1", o, ov, lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
